// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch slice: datapath width, fetch
// queue depth, the fetch state encoding, the queue entry layout and the
// fetch-address legality check.
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN             = 32;
   localparam int FETCH_FIFO_DEPTH = 2;

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // A fetch address is illegal when it is not word aligned or lies at or
   // beyond the end of the instruction memory.
   function automatic logic pc_is_bad(input logic [XLEN-1:0] pc,
                                      input logic [XLEN-1:0] limit);
      return (pc[1:0] != 2'b00) || (pc >= limit);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Two-entry queue of {pc, instr} pairs between fetch and decode.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   push, pop     : enqueue wr_entry / dequeue head (same cycle allowed)
//   flush         : empty the queue and rewind both pointers; wins over push/pop
//   wr_entry      : entry written on push
//   rd_entry      : current head entry
//   full, empty   : occupancy flags
// ---------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t wr_entry,
   output fetch_entry_t rd_entry,
   output logic         full,
   output logic         empty
);

   localparam logic [1:0] DEPTH_CNT = 2'(FETCH_FIFO_DEPTH);

   fetch_entry_t mem_r [FETCH_FIFO_DEPTH];
   logic         wr_ptr_r;
   logic         rd_ptr_r;
   logic [1:0]   count_r;
   logic         push_ok_s;
   logic         pop_ok_s;

   assign full     = (count_r == DEPTH_CNT);
   assign empty    = (count_r == 2'd0);
   assign rd_entry = mem_r[rd_ptr_r];

   // Qualify requests so a stray push into a full queue or pop from an empty
   // one can never corrupt the pointers.
   always_comb begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
      if (pop && !empty) begin
         pop_ok_s = 1'b1;
      end else begin
         pop_ok_s = 1'b0;
      end
      if (push && (!full || pop_ok_s)) begin
         push_ok_s = 1'b1;
      end else begin
         push_ok_s = 1'b0;
      end
   end

   // Pointer, occupancy and storage update.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
         for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_entry;
            wr_ptr_r        <= wr_ptr_r + 1'b1;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetch from a combinational instruction memory into a
// two-entry queue feeding decode, with redirect support and a sticky fault on
// an illegal fetch address.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   instruction_address : byte address to instruction memory (the PC)
//   instruction_data    : memory word at instruction_address, same cycle
//   redirect_valid/
//   redirect_target     : downstream request to restart fetch at a new PC
//   out_valid/out_ready : decode handshake for the queue head
//   out_instr/out_pc    : queue head instruction and its fetch address
//   fault               : sticky fetch fault, cleared only by reset
// ---------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          MEM_DEPTH_BYTES = 1024
)
(
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] instruction_address,
   input  logic [XLEN-1:0] instruction_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            fault
);

   localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_DEPTH_BYTES);

   fetch_state_t    state_r;
   fetch_state_t    state_next_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc_next_s;
   logic            push_s;
   logic            pop_s;
   logic            flush_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   fetch_entry_t    wr_entry_s;
   fetch_entry_t    head_s;

   assign instruction_address = pc_r;
   assign out_valid           = (state_r == RUN) && !fifo_empty_s;
   assign out_instr           = head_s.instr;
   assign out_pc              = head_s.pc;
   assign fault               = (state_r == FAULT);
   assign pop_s               = out_valid && out_ready;
   assign wr_entry_s          = '{pc: pc_r, instr: instruction_data};

   fetch_fifo u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push_s),
      .pop      (pop_s),
      .flush    (flush_s),
      .wr_entry (wr_entry_s),
      .rd_entry (head_s),
      .full     (fifo_full_s),
      .empty    (fifo_empty_s)
   );

   // Next PC / state: redirect beats fetch; a fetch happens only when the
   // queue has room (counting a same-cycle pop) and the PC is legal.
   always_comb begin
      pc_next_s    = pc_r;
      state_next_s = state_r;
      push_s       = 1'b0;
      flush_s      = 1'b0;
      case (state_r)
         RUN: begin
            if (redirect_valid) begin
               flush_s   = 1'b1;
               pc_next_s = redirect_target;
            end else if (!fifo_full_s || pop_s) begin
               if (pc_is_bad(pc_r, MEM_LIMIT)) begin
                  state_next_s = FAULT;
               end else begin
                  push_s    = 1'b1;
                  pc_next_s = pc_r + 32'd4;
               end
            end else begin
               pc_next_s = pc_r;
            end
         end
         FAULT: begin
            state_next_s = FAULT;
         end
         default: begin
            state_next_s = FAULT;
         end
      endcase
   end

   // PC and state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r    <= RESET_PC;
         state_r <= RUN;
      end else begin
         pc_r    <= pc_next_s;
         state_r <= state_next_s;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit with a small combinational instruction memory.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [31:0] instruction_address;
   logic [31:0] instruction_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fault;

   int n_cmp;
   int n_err;

   fetch_unit #(
      .RESET_PC        (32'h0000_0000),
      .MEM_DEPTH_BYTES (1024)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .instruction_address (instruction_address),
      .instruction_data    (instruction_data),
      .redirect_valid      (redirect_valid),
      .redirect_target     (redirect_target),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_instr           (out_instr),
      .out_pc              (out_pc),
      .fault               (fault)
   );

   // Memory contents: two fixed words at 0x0/0x4, elsewhere a tagged address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0000_0013;
      else if (a == 32'h0000_0004) return 32'h0010_0093;
      else return 32'hC0DE_0000 | a;
   endfunction

   always_comb instruction_data = mem_word(instruction_address);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0000_0000;
      out_ready = 1'b0;

      // Reset state
      step();
      step();
      chk1 ("rst_valid", out_valid, 1'b0);
      chk1 ("rst_fault", fault, 1'b0);
      chk32("rst_addr", instruction_address, 32'h0000_0000);

      // Streaming with out_ready held high
      reset = 1'b0;
      out_ready = 1'b1;
      step();
      chk1 ("s1_valid", out_valid, 1'b1);
      chk32("s1_pc", out_pc, 32'h0000_0000);
      chk32("s1_instr", out_instr, 32'h0000_0013);
      chk32("s1_addr", instruction_address, 32'h0000_0004);
      step();
      chk1 ("s2_valid", out_valid, 1'b1);
      chk32("s2_pc", out_pc, 32'h0000_0004);
      chk32("s2_instr", out_instr, 32'h0010_0093);
      step();
      chk32("s3_pc", out_pc, 32'h0000_0008);
      chk32("s3_instr", out_instr, 32'hC0DE_0008);

      // Backpressure: queue fills, PC holds
      reset = 1'b1;
      out_ready = 1'b0;
      step();
      chk1 ("bp_rst_valid", out_valid, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk32("bp_addr_hold", instruction_address, 32'h0000_0008);
      chk1 ("bp_valid", out_valid, 1'b1);
      chk32("bp_head0", out_pc, 32'h0000_0000);
      out_ready = 1'b1;
      step();
      chk32("bp_head1", out_pc, 32'h0000_0004);
      chk32("bp_instr1", out_instr, 32'h0010_0093);
      step();
      chk32("bp_head2", out_pc, 32'h0000_0008);
      chk1 ("bp_valid2", out_valid, 1'b1);

      // Redirect to 0x40 while head is 0x4
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      step();
      chk32("rd_head_pre", out_pc, 32'h0000_0004);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0040;
      step();
      redirect_valid = 1'b0;
      chk1 ("rd_gap_valid", out_valid, 1'b0);
      chk32("rd_addr", instruction_address, 32'h0000_0040);
      step();
      chk1 ("rd_tgt_valid", out_valid, 1'b1);
      chk32("rd_tgt_pc", out_pc, 32'h0000_0040);
      chk32("rd_tgt_instr", out_instr, 32'hC0DE_0040);

      // Redirect to misaligned 0x42 -> fault on next push attempt
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0042;
      step();
      redirect_valid = 1'b0;
      chk1 ("bad_fault_pre", fault, 1'b0);
      chk32("bad_addr", instruction_address, 32'h0000_0042);
      step();
      chk1 ("bad_fault", fault, 1'b1);
      chk1 ("bad_valid", out_valid, 1'b0);
      chk32("bad_addr_hold", instruction_address, 32'h0000_0042);
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0000;
      step();
      redirect_valid = 1'b0;
      step();
      chk32("bad_redir_ignored", instruction_address, 32'h0000_0042);
      chk1 ("bad_fault_sticky", fault, 1'b1);
      chk1 ("bad_valid_sticky", out_valid, 1'b0);

      // Reset with a full queue, then restart
      reset = 1'b1;
      out_ready = 1'b0;
      step();
      chk1 ("fr_fault_clr", fault, 1'b0);
      reset = 1'b0;
      step();
      step();
      chk32("fr_full_addr", instruction_address, 32'h0000_0008);
      chk1 ("fr_full_valid", out_valid, 1'b1);
      reset = 1'b1;
      step();
      chk1 ("fr_rst_valid", out_valid, 1'b0);
      chk32("fr_rst_addr", instruction_address, 32'h0000_0000);
      reset = 1'b0;
      step();
      chk1 ("fr_restart_valid", out_valid, 1'b1);
      chk32("fr_restart_pc", out_pc, 32'h0000_0000);

      // Sequential fetch up to the end of memory
      reset = 1'b1;
      out_ready = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         step();
         chk32("seq_pc", out_pc, 32'(4 * (k - 1)));
      end
      chk1 ("end_valid", out_valid, 1'b1);
      chk32("end_last_pc", out_pc, 32'h0000_03FC);
      chk32("end_last_instr", out_instr, 32'hC0DE_03FC);
      chk1 ("end_fault_pre", fault, 1'b0);
      step();
      chk1 ("end_fault", fault, 1'b1);
      chk1 ("end_valid_post", out_valid, 1'b0);
      chk32("end_addr_hold", instruction_address, 32'h0000_0400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
